// File: rtl/execute_stage.sv
// Execute stage: ALU result (also the memory address) registered into memory-stage inputs, latency 1;
// MUL is an iterative shift-add, stall held for WIDTH cycles, result registered WIDTH+1 cycles after issue.
module execute_stage #(
  parameter int WIDTH      = 24,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  validIn,
  input  logic                  flush,
  input  logic [2:0]            aluOp,
  input  logic [WIDTH-1:0]      srcA,
  input  logic [WIDTH-1:0]      srcB,
  input  logic [WIDTH-1:0]      storeDataIn,
  input  logic [REG_ADDR_W-1:0] regToWriteIn,
  input  logic                  memWeIn,
  input  logic                  writeRegFromAluIn,
  input  logic                  regWeIn,
  output logic                  stall,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      dataToWrite,
  output logic [REG_ADDR_W-1:0] regToWrite,
  output logic                  memWe,
  output logic                  writeRegFromAlu,
  output logic                  regWe
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [5:0]      WIDTH_L  = 6'(WIDTH);
  localparam logic [2:0]      OP_MUL   = 3'b111;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]        mplier_q, mplier_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        sd_hold_q, sd_hold_d;
  logic [REG_ADDR_W-1:0]   rd_hold_q, rd_hold_d;
  logic                    mem_we_hold_q, mem_we_hold_d;
  logic                    wra_hold_q, wra_hold_d;
  logic                    reg_we_hold_q, reg_we_hold_d;

  logic [WIDTH-1:0]        result_q, result_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic                    mem_we_q, mem_we_d;
  logic                    wra_q, wra_d;
  logic                    reg_we_q, reg_we_d;

  logic [WIDTH-1:0]        alu_res;
  logic [WIDTH-1:0]        partial;
  logic [4:0]              shamt;
  logic                    shift_oob;

  assign shamt     = srcB[4:0];
  assign shift_oob = ({1'b0, shamt} >= WIDTH_L);
  assign partial   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    case (aluOp)
      3'b000:  alu_res = srcA + srcB;
      3'b001:  alu_res = srcA - srcB;
      3'b010:  alu_res = srcA & srcB;
      3'b011:  alu_res = srcA | srcB;
      3'b100:  alu_res = srcA ^ srcB;
      3'b101:  alu_res = shift_oob ? '0 : (srcA << shamt);
      3'b110:  alu_res = shift_oob ? '0 : (srcA >> shamt);
      default: alu_res = '0;
    endcase
  end

  // Output registers default to a bubble; only a completing instruction overrides them.
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sd_hold_d     = sd_hold_q;
    rd_hold_d     = rd_hold_q;
    mem_we_hold_d = mem_we_hold_q;
    wra_hold_d    = wra_hold_q;
    reg_we_hold_d = reg_we_hold_q;
    result_d      = '0;
    data_d        = '0;
    rd_d          = '0;
    mem_we_d      = 1'b0;
    wra_d         = 1'b0;
    reg_we_d      = 1'b0;
    stall         = 1'b0;
    case (state_q)
      IDLE: begin
        if (validIn && !flush) begin
          if (aluOp == OP_MUL) begin
            stall         = 1'b1;
            state_d       = BUSY;
            mcand_d       = srcA;
            mplier_d      = srcB;
            acc_d         = '0;
            cnt_d         = '0;
            sd_hold_d     = storeDataIn;
            rd_hold_d     = regToWriteIn;
            mem_we_hold_d = memWeIn;
            wra_hold_d    = writeRegFromAluIn;
            reg_we_hold_d = regWeIn;
          end else begin
            result_d = alu_res;
            data_d   = storeDataIn;
            rd_d     = regToWriteIn;
            mem_we_d = memWeIn;
            wra_d    = writeRegFromAluIn;
            reg_we_d = regWeIn;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          result_d = partial;
          data_d   = sd_hold_q;
          rd_d     = rd_hold_q;
          mem_we_d = mem_we_hold_q;
          wra_d    = wra_hold_q;
          reg_we_d = reg_we_hold_q;
        end else begin
          stall    = 1'b1;
          acc_d    = partial;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      sd_hold_q     <= '0;
      rd_hold_q     <= '0;
      mem_we_hold_q <= 1'b0;
      wra_hold_q    <= 1'b0;
      reg_we_hold_q <= 1'b0;
      result_q      <= '0;
      data_q        <= '0;
      rd_q          <= '0;
      mem_we_q      <= 1'b0;
      wra_q         <= 1'b0;
      reg_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sd_hold_q     <= sd_hold_d;
      rd_hold_q     <= rd_hold_d;
      mem_we_hold_q <= mem_we_hold_d;
      wra_hold_q    <= wra_hold_d;
      reg_we_hold_q <= reg_we_hold_d;
      result_q      <= result_d;
      data_q        <= data_d;
      rd_q          <= rd_d;
      mem_we_q      <= mem_we_d;
      wra_q         <= wra_d;
      reg_we_q      <= reg_we_d;
    end
  end

  assign result          = result_q;
  assign dataToWrite     = data_q;
  assign regToWrite      = rd_q;
  assign memWe           = mem_we_q;
  assign writeRegFromAlu = wra_q;
  assign regWe           = reg_we_q;

endmodule
